// File: rtl/reglk_arb_pkg.sv
// ============================================================================
// Module      : reglk_arb_pkg
// Description : Shared types, defaults and error decode for the register-lock
//               bank access arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reglk_arb_pkg;

    // Transaction sequencing states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Reasons a request is refused at accept time
    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_RANGE = 2'd1,
        ERR_PERM  = 2'd2
    } err_cause_t;

    localparam int         REGLK_NUM_WORDS = 6;
    localparam logic [2:0] REGLK_WR_MASK   = 3'b110;

    // Out-of-range addresses take precedence over permission faults
    function automatic err_cause_t decode_err(
        input logic [31:0] addr,
        input logic [31:0] num_words,
        input logic        we,
        input logic        wr_allowed
    );
        if (addr >= num_words)
            return ERR_RANGE;
        if (we && !wr_allowed)
            return ERR_PERM;
        return ERR_NONE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Searches from ptr+1 upward
//               (wrapping) and returns a one-hot grant plus encoded index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // First valid requester after the pointer wins; the pointer itself is last
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            int cand;
            cand = int'(ptr) + off;
            if (cand >= NUM_REQ)
                cand = cand - NUM_REQ;
            for (int r = 0; r < NUM_REQ; r++) begin
                if (!any && (r == cand) && valid[r]) begin
                    any      = 1'b1;
                    grant[r] = 1'b1;
                    idx      = IDX_W'(r);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/reglk_access_arb.sv
// ============================================================================
// Module      : reglk_access_arb
// Description : Grants one requester at a time to the register-lock bank,
//               checks range/permission, performs a single bank access and
//               returns read data or an error to the granted requester.
//               Optional macro REGLK_ARB_DBG_PRIO_EN gives requester 0 (debug)
//               absolute priority without moving the round-robin pointer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reglk_access_arb
    import reglk_arb_pkg::*;
#(
    parameter int                 NUM_REQ   = 3,
    parameter int                 NUM_WORDS = REGLK_NUM_WORDS,
    parameter int                 ADDR_W    = 3,
    parameter int                 DATA_W    = 32,
    parameter int                 MEM_LAT   = 0,
    parameter logic [NUM_REQ-1:0] WR_MASK   = NUM_REQ'(REGLK_WR_MASK)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ-1:0]        req_we_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]         rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      mem_en_o,
    output logic                      mem_we_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [DATA_W-1:0]         mem_wdata_o,
    input  logic [DATA_W-1:0]         mem_rdata_i,
    output logic                      busy_o
);

    localparam int               IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int               CNT_W     = 2;
    localparam logic [CNT_W-1:0] WAIT_INIT = (MEM_LAT > 0) ? CNT_W'(MEM_LAT - 1) : '0;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic               dbg_win;
    logic [NUM_REQ-1:0] win_grant;
    logic [IDX_W-1:0]   win_idx;
    logic               accept;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_wr_ok;
    err_cause_t         acc_err;
    logic [NUM_REQ-1:0] lat_grant;
    logic               lat_we;
    logic [CNT_W-1:0]   wait_cnt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .valid (req_valid_i),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

`ifdef REGLK_ARB_DBG_PRIO_EN
    assign dbg_win = req_valid_i[0];
`else
    assign dbg_win = 1'b0;
`endif

    assign win_grant = dbg_win ? NUM_REQ'(1) : arb_grant;
    assign win_idx   = dbg_win ? '0 : arb_idx;

    // Ready is only offered from IDLE, and never while reset is held
    assign accept      = (state == ST_IDLE) && !rst_i && arb_any;
    assign req_ready_o = accept ? win_grant : '0;
    assign busy_o      = (state != ST_IDLE);

    // Pick out the winner's payload and write permission
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wr_ok = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (win_idx == IDX_W'(r)) begin
                sel_we    = req_we_i[r];
                sel_addr  = req_addr_i[r*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata_i[r*DATA_W +: DATA_W];
                sel_wr_ok = WR_MASK[r];
            end
        end
    end

    assign acc_err = decode_err(32'(sel_addr), 32'(NUM_WORDS), sel_we, sel_wr_ok);

    // Transaction sequencer with registered bank and response outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            rr_ptr      <= IDX_W'(NUM_REQ - 1);
            lat_grant   <= '0;
            lat_we      <= 1'b0;
            wait_cnt    <= '0;
            mem_en_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            rsp_valid_o <= '0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_grant <= win_grant;
                        lat_we    <= sel_we;
                        if (!dbg_win)
                            rr_ptr <= win_idx;
                        if (acc_err != ERR_NONE) begin
                            // Refused requests skip the bank entirely
                            state       <= ST_RESP;
                            rsp_valid_o <= win_grant;
                            rsp_err_o   <= 1'b1;
                            rsp_rdata_o <= '0;
                        end else begin
                            state       <= ST_ACCESS;
                            mem_en_o    <= 1'b1;
                            mem_we_o    <= sel_we;
                            mem_addr_o  <= sel_addr;
                            mem_wdata_o <= sel_wdata;
                        end
                    end
                end
                ST_ACCESS: begin
                    mem_en_o    <= 1'b0;
                    mem_we_o    <= 1'b0;
                    mem_addr_o  <= '0;
                    mem_wdata_o <= '0;
                    if (MEM_LAT == 0) begin
                        state       <= ST_RESP;
                        rsp_valid_o <= lat_grant;
                        rsp_err_o   <= 1'b0;
                        rsp_rdata_o <= lat_we ? '0 : mem_rdata_i;
                    end else begin
                        state    <= ST_WAIT;
                        wait_cnt <= WAIT_INIT;
                    end
                end
                ST_WAIT: begin
                    // Bank data is valid on the final wait cycle
                    if (wait_cnt == '0) begin
                        state       <= ST_RESP;
                        rsp_valid_o <= lat_grant;
                        rsp_err_o   <= 1'b0;
                        rsp_rdata_o <= lat_we ? '0 : mem_rdata_i;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    state       <= ST_IDLE;
                    rsp_valid_o <= '0;
                    rsp_err_o   <= 1'b0;
                    rsp_rdata_o <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
